// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters with decoded, registered x/y/valid/sync outputs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048 || V_ACTIVE > 1024) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 2048 and V_ACTIVE <= 1024");
    end

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    // Sync window bounds carry a 12th bit so a window ending exactly at 2048 still decodes
    localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ACT   = (HS_POL != 0);
    localparam logic        VS_ACT   = (VS_POL != 0);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic        in_active;
    logic        at_origin;

    always_comb begin
        h_ext     = {1'b0, h_cnt_q};
        v_ext     = {1'b0, v_cnt_q};
        in_active = (h_ext < H_ACT_W) && (v_ext < V_ACT_W);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        valid_d       = valid_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        frame_count_d = frame_count_q;

        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end

            valid_d       = in_active;
            x_d           = in_active ? h_cnt_q : '0;
            y_d           = in_active ? v_cnt_q[9:0] : '0;
            hsync_d       = (h_ext >= HS_BEG && h_ext < HS_END) ? HS_ACT : ~HS_ACT;
            vsync_d       = (v_ext >= VS_BEG && v_ext < VS_END) ? VS_ACT : ~VS_ACT;
            frame_start_d = at_origin;
            frame_count_d = frame_count_q + (at_origin ? 16'd1 : 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            valid_q       <= 1'b0;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    assign frame_count = frame_count_q;
`else
    logic unused_frame_count;
    assign unused_frame_count = ^frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size instance plus a tiny-raster instance, checked
// against an arithmetic pixel-index model; frame_count checked when VGA_TIMING_FRAME_CNT_EN is set.
module tb_vga_timing_gen;

    localparam int HA_A = 1280, HF_A = 48, HS_A = 112, HB_A = 248;
    localparam int VA_A = 1024, VF_A = 1,  VS_A = 3,   VB_A = 38;
    localparam int HA_B = 4, HF_B = 1, HS_B = 1, HB_B = 1;
    localparam int VA_B = 3, VF_B = 1, VS_B = 1, VB_B = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    logic [10:0] x_a, x_b;
    logic [9:0]  y_a, y_b;
    logic        valid_a, valid_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x_a), .y(y_a), .valid(valid_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count(fc_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
        .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x_b), .y(y_b), .valid(valid_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count(fc_b)
`endif
    );

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        en;
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    int total = 0;
    int bad = 0;
    longint k = 0;  // enabled edges since last reset; 0 means outputs hold reset values

    // Output after k enabled edges shows the raster position of pixel index k-1.
    function automatic obs_t model(int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, longint kk);
        obs_t o;
        int ht, vt, h, v;
        longint idx, ft;
        o = '0;
        if (kk == 0) return o;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        ft  = longint'(ht) * longint'(vt);
        idx = kk - 1;
        h   = int'(idx % longint'(ht));
        v   = int'((idx / longint'(ht)) % longint'(vt));
        o.valid = (h < ha) && (v < va);
        o.x     = o.valid ? 11'(h) : '0;
        o.y     = o.valid ? 10'(v) : '0;
        o.hs    = (h >= ha + hf) && (h < ha + hf + hsw);
        o.vs    = (v >= va + vf) && (v < va + vf + vsw);
        o.fs    = (idx % ft) == 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc    = 16'((kk + ft - 1) / ft);
`endif
        return o;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '0;
        o.x = x_a; o.y = y_a; o.valid = valid_a; o.hs = hs_a; o.vs = vs_a; o.fs = fs_a;
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc = fc_a;
`endif
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '0;
        o.x = x_b; o.y = y_b; o.valid = valid_b; o.hs = hs_b; o.vs = vs_b; o.fs = fs_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc = fc_b;
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset  = r;
        pix_en = e;
        @(posedge clk);
        if (r) k = 0;
        else if (e) k++;
        #1;
        check("model_a", 64'(obs_a()), 64'(model(HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, VB_A, k)));
        check("model_b", 64'(obs_b()), 64'(model(HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B, k)));
    endtask

    vec_t tbl[10];
    int hs_cnt, hs_first, hs_last, vs_cnt;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 11'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 11'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 11'd2, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].en);
            check($sformatf("vec%0d", i),
                  64'({x_a, y_a, valid_a, hs_a, vs_a, fs_a}),
                  64'({tbl[i].x, tbl[i].y, tbl[i].valid, tbl[i].hs, tbl[i].vs, tbl[i].fs}));
        end

        // One full default line plus the first pixel of the next line.
        step(1'b1, 1'b1);
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int c = 1; c <= 1689; c++) begin
            step(1'b0, 1'b1);
            if (hs_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            if (c == 1280) check("line_last_px", 64'({x_a, valid_a}), 64'({11'd1279, 1'b1}));
            if (c == 1281) check("line_blank", 64'({x_a, valid_a}), 64'({11'd0, 1'b0}));
            if (c == 1689) check("line2_first", 64'({x_a, y_a, valid_a}), 64'({11'd0, 10'd1, 1'b1}));
        end
        check("hsync_len", 64'(hs_cnt), 64'(112));
        check("hsync_first", 64'(hs_first), 64'(1329));
        check("hsync_last", 64'(hs_last), 64'(1440));

        // Full small frame with random stalls: vsync spans exactly one 7-pixel line.
        step(1'b1, 1'b1);
        vs_cnt = 0;
        for (int c = 1; c <= 42; c++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            if (vs_b) vs_cnt++;
        end
        check("vsync_len", 64'(vs_cnt), 64'(7));
        step(1'b0, 1'b1);
        check("frame_restart", 64'({x_b, y_b, valid_b, fs_b}), 64'({11'd0, 10'd0, 1'b1, 1'b1}));

        // Stall mid-line at x=500.
        step(1'b1, 1'b0);
        for (int c = 1; c <= 501; c++) step(1'b0, 1'b1);
        check("stall_pre", 64'(x_a), 64'(500));
        step(1'b0, 1'b0);
        check("stall_hold1", 64'(x_a), 64'(500));
        step(1'b0, 1'b0);
        check("stall_hold2", 64'(x_a), 64'(500));
        step(1'b0, 1'b1);
        check("stall_resume", 64'(x_a), 64'(501));

        // Reset mid-frame at row 2, column 3 of the small raster.
        step(1'b1, 1'b1);
        for (int c = 1; c <= 18; c++) step(1'b0, 1'b1);
        check("mid_pos", 64'({x_b, y_b, valid_b}), 64'({11'd3, 10'd2, 1'b1}));
        step(1'b1, 1'b1);
        check("mid_reset", 64'({x_b, y_b, valid_b, hs_b, vs_b, fs_b}), 64'(0));
        step(1'b0, 1'b1);
        check("mid_restart", 64'({x_b, y_b, valid_b, fs_b}), 64'({11'd0, 10'd0, 1'b1, 1'b1}));

`ifdef VGA_TIMING_FRAME_CNT_EN
        step(1'b1, 1'b1);
        for (int c = 1; c <= 126; c++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        check("frame_count_3", 64'(fc_b), 64'(3));
        step(1'b1, 1'b0);
        check("frame_count_rst", 64'(fc_b), 64'(0));
`endif

        // Random enables with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
